// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage. FAULT state exists only when
// FETCH_ALIGN_CHECK_EN is defined.
package fetch_pkg;

  localparam int INSTR_BYTES = 4;

`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1
  } fetch_state_e;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer of fetch_entry_t with flush. The head entry is
// read straight from storage so decode sees it with no added latency.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t data_i,
  input  logic         pop_i,
  output fetch_entry_t data_o,
  output logic         valid_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q, rdPtr_q;
  logic [CW-1:0] count_q, count_d;
  logic          doPop, full;

  always_comb begin
    valid_o = (count_q != '0);
    full    = (count_q == CW'(DEPTH));
    doPop   = pop_i && valid_o;
    count_d = count_q + CW'(push_i) - CW'(doPop);
    data_o  = valid_o ? mem_q[rdPtr_q] : '0;
    count_o = count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wrPtr_q] <= data_i;
        wrPtr_q        <= wrPtr_q + 1'b1;
      end
      if (doPop) rdPtr_q <= rdPtr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // The upstream credit limit must make this impossible.
  noOverflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && !flush_i && full && !doPop));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues credit-limited word requests and
// buffers returns for decode. FETCH_ALIGN_CHECK_EN adds a sticky misaligned-redirect fault.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic        fetch_fault,
`endif
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   reqPc_q, reqPc_d, rspPc_q, rspPc_d, redirTarget;
  logic [CW-1:0] outstanding_q, outstanding_d, killCnt_q, killCnt_d, fifoCount;
  logic [CW:0]   inFlight;
  logic          reqFire, rspKeep, fifoPop;
  fetch_entry_t  pushEntry, headEntry;

  always_comb begin
    redirTarget    = redirect_pc & ~32'(INSTR_BYTES - 1);
    inFlight       = {1'b0, outstanding_q} + {1'b0, fifoCount};
    imem_req_valid = (state_q == RUN) && !redirect_valid
                     && (inFlight < (CW+1)'(FIFO_DEPTH));
    imem_req_addr  = reqPc_q;
    reqFire        = imem_req_valid && imem_req_ready;
    // Responses still owed to a flushed path are consumed by killCnt, never buffered.
    rspKeep        = imem_rsp_valid && (killCnt_q == '0) && !redirect_valid;
    fifoPop        = inst_valid && inst_ready && !redirect_valid;
    pushEntry      = '{pc: rspPc_q, instr: imem_rsp_data};
    inst_data      = headEntry.instr;
    inst_pc        = headEntry.pc;
  end

  always_comb begin
    state_d       = state_q;
    reqPc_d       = reqPc_q;
    rspPc_d       = rspPc_q;
    killCnt_d     = killCnt_q;
    outstanding_d = outstanding_q + CW'(reqFire) - CW'(imem_rsp_valid);
    case (state_q)
      IDLE:    state_d = RUN;
      default: state_d = state_q;
    endcase
    if (reqFire) reqPc_d = reqPc_q + 32'(INSTR_BYTES);
    if (rspKeep) rspPc_d = rspPc_q + 32'(INSTR_BYTES);
    if (imem_rsp_valid && (killCnt_q != '0)) killCnt_d = killCnt_q - 1'b1;
    if (redirect_valid) begin
      reqPc_d   = redirTarget;
      rspPc_d   = redirTarget;
      killCnt_d = outstanding_q - CW'(imem_rsp_valid);
`ifdef FETCH_ALIGN_CHECK_EN
      if (redirect_pc[1:0] != 2'b00) state_d = FAULT;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      reqPc_q       <= RESET_PC;
      rspPc_q       <= RESET_PC;
      outstanding_q <= '0;
      killCnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      reqPc_q       <= reqPc_d;
      rspPc_q       <= rspPc_d;
      outstanding_q <= outstanding_d;
      killCnt_q     <= killCnt_d;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  assign fetch_fault = (state_q == FAULT);
`endif

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_valid),
    .push_i  (rspKeep),
    .data_i  (pushEntry),
    .pop_i   (fifoPop),
    .data_o  (headEntry),
    .valid_o (inst_valid),
    .count_o (fifoCount)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a fixed-latency instruction memory model
// whose returned word is derived from the request address.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_data, inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_fault;
`endif

  int vectors = 0;
  int miscompares = 0;
  int memLat = 1;

  logic        pipeV    [4];
  logic [31:0] pipeAddr [4];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
`ifdef FETCH_ALIGN_CHECK_EN
    .fetch_fault    (fetch_fault),
`endif
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Memory model: accepted requests shift down a pipe; tap memLat-1 is the response.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        pipeV[i]    <= 1'b0;
        pipeAddr[i] <= '0;
      end
    end else begin
      pipeV[0]    <= imem_req_valid && imem_req_ready;
      pipeAddr[0] <= imem_req_addr;
      for (int i = 1; i < 4; i++) begin
        pipeV[i]    <= pipeV[i-1];
        pipeAddr[i] <= pipeAddr[i-1];
      end
    end
  end

  assign imem_rsp_valid = pipeV[memLat-1];
  assign imem_rsp_data  = memWord(pipeAddr[memLat-1]);

  task automatic applyStimulus(input logic reqReady, input logic instReady,
                               input logic redirV, input logic [31:0] redirPc);
    imem_req_ready = reqReady;
    inst_ready     = instReady;
    redirect_valid = redirV;
    redirect_pc    = redirPc;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic resetDut(input int lat);
    rst_n  = 1'b0;
    memLat = lat;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    rst_n  = 1'b0;
    memLat = 1;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    #1;
    checkOutput("rst_req_valid",  32'(imem_req_valid), 32'h0);
    checkOutput("rst_inst_valid", 32'(inst_valid),     32'h0);
    checkOutput("rst_inst_data",  inst_data,           32'h0);
    checkOutput("rst_inst_pc",    inst_pc,             32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
    checkOutput("rst_fault",      32'(fetch_fault),    32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming, 1-cycle memory, decode always ready
    step();
    checkOutput("s_req_valid0", 32'(imem_req_valid), 32'h1);
    checkOutput("s_addr0",      imem_req_addr,       32'h0);
    checkOutput("s_ivalid_c1",  32'(inst_valid),     32'h0);
    step();
    checkOutput("s_addr4",      imem_req_addr,       32'h4);
    checkOutput("s_ivalid_c2",  32'(inst_valid),     32'h0);
    step();
    checkOutput("s_ivalid_c3",  32'(inst_valid),     32'h1);
    checkOutput("s_pc0",        inst_pc,             32'h0);
    checkOutput("s_data0",      inst_data,           memWord(32'h0));
    checkOutput("s_addr8",      imem_req_addr,       32'h8);
    step();
    checkOutput("s_pc4",        inst_pc,             32'h4);
    step();
    checkOutput("s_pc8",        inst_pc,             32'h8);
    checkOutput("s_data8",      inst_data,           memWord(32'h8));

    // Decode stalled: credit limit stops requests at 4 in flight
    resetDut(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    step();
    step();
    step();
    checkOutput("f_addrC",      imem_req_addr,       32'hC);
    checkOutput("f_valid_c4",   32'(imem_req_valid), 32'h1);
    step();
    checkOutput("f_valid_c5",   32'(imem_req_valid), 32'h0);
    step();
    checkOutput("f_valid_c6",   32'(imem_req_valid), 32'h0);
    step();
    checkOutput("f_valid_c7",   32'(imem_req_valid), 32'h0);
    checkOutput("f_head_pc0",   inst_pc,             32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    step();
    checkOutput("f_pc4",        inst_pc,             32'h4);
    checkOutput("f_resume",     32'(imem_req_valid), 32'h1);
    checkOutput("f_addr10",     imem_req_addr,       32'h10);
    step();
    checkOutput("f_pc8",        inst_pc,             32'h8);
    step();
    checkOutput("f_pcC",        inst_pc,             32'hC);
    step();
    checkOutput("f_pc10",       inst_pc,             32'h10);

    // Latency 3, two requests in flight, redirect to 0x100
    resetDut(3);
    step();
    step();
    checkOutput("k_addr4",      imem_req_addr,       32'h4);
    step();
    checkOutput("k_addr8",      imem_req_addr,       32'h8);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h100);
    checkOutput("k_noreq",      32'(imem_req_valid), 32'h0);
    step();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("k_addr100",    imem_req_addr,       32'h100);
    checkOutput("k_ivalid_a",   32'(inst_valid),     32'h0);
    step();
    checkOutput("k_ivalid_b",   32'(inst_valid),     32'h0);
    step();
    checkOutput("k_ivalid_c",   32'(inst_valid),     32'h0);
    step();
    checkOutput("k_ivalid_d",   32'(inst_valid),     32'h0);
    step();
    checkOutput("k_ivalid_e",   32'(inst_valid),     32'h1);
    checkOutput("k_pc100",      inst_pc,             32'h100);
    checkOutput("k_data100",    inst_data,           memWord(32'h100));

    // Redirect coinciding with a response and a pop
    resetDut(1);
    step();
    step();
    step();
    checkOutput("c_head_valid", 32'(inst_valid),     32'h1);
    checkOutput("c_head_pc0",   inst_pc,             32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h200);
    step();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("c_flushed",    32'(inst_valid),     32'h0);
    checkOutput("c_req_valid",  32'(imem_req_valid), 32'h1);
    checkOutput("c_addr200",    imem_req_addr,       32'h200);
    step();
    step();
    checkOutput("c_ivalid",     32'(inst_valid),     32'h1);
    checkOutput("c_pc200",      inst_pc,             32'h200);
    checkOutput("c_data200",    inst_data,           memWord(32'h200));

    // Memory not ready for 5 cycles: address held
    resetDut(1);
    step();
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("h_addr_0",     imem_req_addr,       32'h4);
    checkOutput("h_valid_0",    32'(imem_req_valid), 32'h1);
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput("h_addr_hold", imem_req_addr,      32'h4);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    step();
    checkOutput("h_addr8",      imem_req_addr,       32'h8);

    // Misaligned redirect target
    resetDut(1);
    step();
    step();
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h102);
    checkOutput("m_noreq",      32'(imem_req_valid), 32'h0);
    step();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
    checkOutput("m_fault",      32'(fetch_fault),    32'h1);
    checkOutput("m_stop",       32'(imem_req_valid), 32'h0);
    step();
    step();
    step();
    checkOutput("m_fault_hold", 32'(fetch_fault),    32'h1);
    checkOutput("m_stop_hold",  32'(imem_req_valid), 32'h0);
    resetDut(1);
    checkOutput("m_fault_clr",  32'(fetch_fault),    32'h0);
    step();
    checkOutput("m_restart",    32'(imem_req_valid), 32'h1);
    checkOutput("m_addr0",      imem_req_addr,       32'h0);
`else
    checkOutput("m_req_valid",  32'(imem_req_valid), 32'h1);
    checkOutput("m_addr100",    imem_req_addr,       32'h100);
    checkOutput("m_ivalid",     32'(inst_valid),     32'h0);
    step();
    step();
    checkOutput("m_pc100",      inst_pc,             32'h100);
    checkOutput("m_ivalid2",    32'(inst_valid),     32'h1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the decode stage.
- Owns the PC and issues in-order word requests to instruction memory over a valid/ready channel.
- Buffers returned words with their PC in a small FIFO and presents them to decode over a valid/ready channel.
- Accepts redirects (taken branches) from execute, flushing wrong-path state.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 4, instruction buffer entries; also the cap on outstanding requests plus buffered entries (power of two, at least 2).

Ports:
- clk  input  1  single clock; all state changes on posedge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  32  word-aligned fetch address.
- imem_rsp_valid  input  1  response word valid; in-order; always accepted, no backpressure.
- imem_rsp_data  input  32  returned instruction.
- inst_valid  output  1  buffered instruction available to decode.
- inst_ready  input  1  decode consumes head.
- inst_data  output  32  head instruction.
- inst_pc  output  32  PC of head instruction.
- redirect_valid  input  1  execute redirect, single-cycle pulse.
- redirect_pc  input  32  redirect target.
- fetch_fault  output  1  sticky misaligned-target flag; present only under FETCH_ALIGN_CHECK_EN.

Behaviour:
- Reset (async, rst_n=0):
  - req_pc=RESET_PC, rsp_pc=RESET_PC.
  - outstanding=0, kill_cnt=0, FIFO empty.
  - FSM=IDLE; imem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=0, fetch_fault=0.
- FSM:
  - IDLE: one cycle after reset release, no request; then RUN.
  - RUN: normal fetching.
  - FAULT: exists only with the macro; no requests; left only by reset.
- Request issue:
  - imem_req_valid = (state==RUN) && !redirect_valid && (outstanding + fifo_count < FIFO_DEPTH).
  - imem_req_addr = req_pc.
  - On handshake: req_pc += 4 (wraps mod 2^32); outstanding += 1.
  - Address is held stable while valid and not ready.
- Response:
  - Each imem_rsp_valid decrements outstanding.
  - If kill_cnt>0: response is dropped and kill_cnt -= 1.
  - Otherwise {rsp_pc, data} is pushed into the FIFO and rsp_pc += 4.
  - The credit rule guarantees the FIFO never overflows; an assertion checks this.
- Decode side:
  - inst_valid = FIFO non-empty; inst_data/inst_pc come from the head entry (registered storage, zero added latency).
  - Pop on inst_valid && inst_ready.
  - Push and pop in the same cycle leave the count unchanged.
- Latency: request accepted at cycle N with a 1-cycle memory gives a response at N+1 and inst_valid at N+2. Sustained throughput is 1 instruction/cycle when memory latency + 1 <= FIFO_DEPTH.
- Redirect (redirect_valid=1), all in one cycle:
  - FIFO flushed; any simultaneous pop or push is discarded.
  - req_pc <= redirect_pc and rsp_pc <= redirect_pc.
  - kill_cnt <= outstanding - imem_rsp_valid, since the same-cycle response is itself dropped.
  - No request is issued that cycle.
  - inst_valid=0 from the next cycle until the first new-path response.
- Back-to-back redirects: the last one wins; the kill_cnt formula applies each cycle.
- Counter widths: $clog2(FIFO_DEPTH)+1 bits for outstanding, kill_cnt and fifo_count.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- With it defined:
  - A redirect with redirect_pc[1:0]!=0 sets fetch_fault=1 (sticky).
  - FSM moves to FAULT; FIFO flushed; outstanding responses are killed as for a normal redirect.
  - No further requests until reset.
- Without it:
  - fetch_fault port is absent and there is no FAULT state.
  - redirect_pc[1:0] is ignored (forced to 2'b00).

Decomposition:
- Package fetch_pkg:
  - fetch_state_e (IDLE, RUN, FAULT).
  - fetch_entry_t struct {pc[31:0], instr[31:0]}.
  - Constant INSTR_BYTES=4.
- Sub-module fetch_fifo: parameterised sync FIFO of fetch_entry_t with flush, count, push/pop; instantiated once.

Test Plan:
- Reset release, memory always ready, 1-cycle latency, inst_ready=1 -> requests 0x0, 0x4, 0x8 on consecutive cycles; inst_valid first at cycle 3 after reset with inst_pc=0x0, then one instruction per cycle.
- inst_ready=0 held -> FIFO fills to 4; imem_req_valid drops once outstanding+count=4; on release, PCs 0x0..0xC drain in order, no loss.
- Memory latency 3 with 2 requests outstanding, redirect to 0x100 -> both stale responses dropped (kill_cnt 2->0); first inst_pc=0x100.
- Redirect in the same cycle as imem_rsp_valid and inst_ready -> response dropped, pop discarded, FIFO empty next cycle, next request addr=redirect_pc.
- imem_req_ready=0 for 5 cycles -> imem_req_addr stable at the pending PC; no PC advance.
- With FETCH_ALIGN_CHECK_EN: redirect_pc=0x102 -> fetch_fault=1 next cycle, imem_req_valid stays 0 until rst_n pulse; without the macro, fetch resumes at 0x100.
